// File: rtl/adc_sample_averager.sv
// Paces getV requests to SPI_Driver, sums 2^LOG2_N samples and offers their truncated mean on a valid/ready port.
// Optional REQ watchdog with sticky timeoutErr: define SPI_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for en with vReady low
// REQ   | getV high, capture first vReady
// DROP  | wait for vReady low, then GAP or OUT
// GAP   | inter-sample idle down-count
// OUT   | avgValid high until avgReady
module adc_sample_averager #(
  parameter int DATA_W  = 10,
  parameter int LOG2_N  = 2,
  parameter int GAP     = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  output logic              getV,
  input  logic              vReady,
  input  logic [DATA_W-1:0] v,
  output logic [DATA_W-1:0] avg,
  output logic              avgValid,
  input  logic              avgReady,
  output logic              timeoutErr
);

  localparam int AW = DATA_W + LOG2_N;
  localparam int CW = LOG2_N + 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] N_SAMP = CW'(1 << LOG2_N);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_DROP = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [DATA_W-1:0] avg_q, avg_d;

`ifdef SPI_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] to_q, to_d;
  logic          terr_q, terr_d;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    avg_d   = avg_q;
`ifdef SPI_TIMEOUT_EN
    to_d    = to_q;
    terr_d  = terr_q;
`endif
    case (state_q)
      S_IDLE: begin
        // a stale vReady from a previous conversion must clear before requesting
        if (en && !vReady) begin
          state_d = S_REQ;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef SPI_TIMEOUT_EN
          to_d    = TW'(TIMEOUT - 1);
`endif
        end
      end
      S_REQ: begin
        if (vReady) begin
          acc_d   = acc_q + AW'(v);
          cnt_d   = cnt_q + 1'b1;
          state_d = S_DROP;
        end
`ifdef SPI_TIMEOUT_EN
        else if (to_q == '0) begin
          terr_d  = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_DROP;
        end else begin
          to_d = to_q - 1'b1;
        end
`endif
      end
      S_DROP: begin
        if (!vReady) begin
          if (cnt_q == N_SAMP) begin
            avg_d   = acc_q[AW-1:LOG2_N];
            state_d = S_OUT;
          end else begin
            gap_d   = GW'(GAP);
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_REQ;
`ifdef SPI_TIMEOUT_EN
          to_d    = TW'(TIMEOUT - 1);
`endif
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_OUT: begin
        if (avgReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      avg_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      avg_q   <= avg_d;
    end
  end

`ifdef SPI_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      to_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      to_q   <= to_d;
      terr_q <= terr_d;
    end
  end
  assign timeoutErr = terr_q;
`else
  assign timeoutErr = 1'b0;
`endif

  // outputs decode straight from state so RST removes getV without waiting for a clock
  assign getV     = (state_q == S_REQ);
  assign avgValid = (state_q == S_OUT);
  assign avg      = avg_q;

endmodule
